load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Multi-cycle MIPS32 memory-access stage, directly downstream of the immediate sign extender.
- Consumes the 32-bit sign-extended offset and the base register value, and forms the effective address (EA = base + offset).
- Runs one request/acknowledge transaction with data memory and returns sign- or zero-extended load data to writeback.
- Handles LW/LH/LHU/LB/LBU/SW/SH/SB, with alignment checking and a bounded wait for memory.

Parameters:
- TIMEOUT, default 16: maximum cycles mem_req is held without mem_ack before the access aborts. Must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin an access; sampled only in IDLE.
- op  input  3  access type: 000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU, 101 SW, 110 SH, 111 SB.
- base  input  32  base register value (rs).
- offset_ext  input  32  sign-extended immediate from sign extender.
- store_data  input  32  rt value for stores; low byte/half used for SB/SH.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.
- load_data  output  32  extended load result; valid while done is high; held until the next done.
- misaligned  output  1  valid with done; access rejected for alignment.
- timeout_err  output  1  valid with done; memory did not acknowledge in time.
- mem_req  output  1  memory request; held until mem_ack or timeout.
- mem_we  output  1  write enable, stable while mem_req is high.
- mem_addr  output  32  word address, {EA[31:2],2'b00}.
- mem_wdata  output  32  store data replicated into its lanes: SB gives {4{b}}, SH gives {2{h}}.
- mem_be  output  4  byte enables, little-endian, lane = EA[1:0].
- mem_ack  input  1  memory acknowledge, one cycle per transaction.
- mem_rdata  input  32  read word; valid in the mem_ack cycle.

Behaviour:
- Reset (async, rst_n low): state IDLE, all outputs 0, timeout counter 0.
- Reset asserted mid-transaction drops mem_req immediately, with no done pulse.
- State IDLE:
  - start=1 latches op, base, offset_ext and store_data.
  - Goes to ADDR; busy rises the next cycle.
  - start while busy is ignored and not queued.
- State ADDR (1 cycle):
  - EA = base + offset_ext, mod 2^32; overflow is ignored and wrap-around is legal.
  - Alignment check: LW/SW require EA[1:0]=00; LH/LHU/SH require EA[0]=0; byte ops are always aligned.
  - If misaligned, goes to DONE with misaligned=1 and never asserts mem_req.
  - Otherwise registers mem_addr, mem_we, mem_be and mem_wdata, and goes to REQ.
- Byte enables:
  - Word: 1111.
  - Half: 0011 when EA[1]=0, 1100 when EA[1]=1.
  - Byte: 0001 shifted left by EA[1:0].
- State REQ:
  - mem_req=1, with address, data and enables stable.
  - The counter increments each cycle without ack.
  - mem_ack: capture the lane selected by EA[1:0] from mem_rdata, then go to DONE.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; stores leave load_data unchanged.
  - After TIMEOUT cycles without ack: drop mem_req, go to DONE with timeout_err=1.
  - An ack arriving in the same cycle the counter reaches TIMEOUT is treated as success.
- State DONE (1 cycle):
  - done=1, busy=0, mem_req=0, then returns to IDLE.
  - misaligned and timeout_err are valid only with done and are cleared on the next start.
- Latency with zero-wait memory:
  - start at cycle 0, mem_req at cycle 2, ack at cycle 2, done at cycle 3.
  - Each memory wait cycle adds one cycle.
  - A misaligned access gives done at cycle 2.
- mem_ack outside REQ is ignored.
- A new start is accepted in the cycle after done (IDLE), giving back-to-back throughput of one access per 4 cycles.

Test Plan:
- LW, base=0x1000, offset_ext=0xFFFFFFFC (imm -4), memory acks same cycle with 0xDEADBEEF -> mem_addr=0x00000FFC, mem_be=1111, mem_we=0, done at cycle 3, load_data=0xDEADBEEF, no error flags.
- LB/LBU at EA=0x2003 with mem_rdata=0x80FF1234 -> mem_be=1000; LB gives load_data=0xFFFFFF80; LBU gives 0x00000080.
- SH, base=0x3000, offset=2, store_data=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD; done after ack; load_data unchanged.
- LW at EA=0x4002 (misaligned) -> mem_req never asserted, done at cycle 2 with misaligned=1; next start with aligned EA clears the flag.
- TIMEOUT=16, no mem_ack -> mem_req high exactly 16 cycles, then done with timeout_err=1. Repeat with ack on the 16th cycle -> success, timeout_err=0.
- Each of the following:
  - rst_n pulsed low while in REQ -> mem_req, busy and done go to 0 asynchronously; after release the unit is in IDLE and accepts start.
  - start asserted while busy -> ignored.
  - base=0xFFFFFFFC, offset=8 -> EA wraps to 0x00000004.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle MIPS32 memory-access stage.
// Forms EA = base + offset_ext, checks alignment, and runs one req/ack
// transaction with data memory. Loads return sign/zero-extended lane data.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   start, op              access request (sampled in IDLE) and access type
//   base, offset_ext       address operands
//   store_data             rt value for stores
//   busy, done             in-flight indicator, one-cycle completion pulse
//   load_data              extended load result, held until the next done
//   misaligned, timeout_err  completion status, valid with done
//   mem_req/we/addr/wdata/be  memory request side
//   mem_ack, mem_rdata     memory response side
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] base,
    input  logic [31:0] offset_ext,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        timeout_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_REQ, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_LW = 3'b000, OP_LH = 3'b001, OP_LB = 3'b010, OP_LHU = 3'b011,
        OP_LBU = 3'b100, OP_SW = 3'b101, OP_SH = 3'b110, OP_SB = 3'b111
    } op_e;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [31:0]     base_q, base_d;
    logic [31:0]     off_q, off_d;
    logic [31:0]     sdata_q, sdata_d;
    logic [1:0]      lane_q, lane_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     ldata_q, ldata_d;
    logic            mis_q, mis_d;
    logic            tmo_q, tmo_d;

    logic [31:0] ea;
    logic        is_store, is_word, is_half, mis_now;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, shifted, ld_ext;

    always_comb begin
        ea       = base_q + off_q;
        is_store = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
        is_word  = (op_q == OP_LW) || (op_q == OP_SW);
        is_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
        mis_now  = is_word ? (ea[1:0] != 2'b00) : (is_half ? ea[0] : 1'b0);

        if (is_word) begin
            be_calc    = 4'b1111;
            wdata_calc = sdata_q;
        end else if (is_half) begin
            be_calc    = ea[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{sdata_q[15:0]}};
        end else begin
            be_calc    = 4'b0001 << ea[1:0];
            wdata_calc = {4{sdata_q[7:0]}};
        end

        // Bring the addressed lane down to bit 0 before extending.
        shifted = mem_rdata >> {lane_q, 3'b000};
        unique case (op_q)
            OP_LH:   ld_ext = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  ld_ext = {16'h0000, shifted[15:0]};
            OP_LB:   ld_ext = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  ld_ext = {24'h000000, shifted[7:0]};
            default: ld_ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        base_d  = base_q;
        off_d   = off_q;
        sdata_d = sdata_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        mis_d   = mis_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    base_d  = base;
                    off_d   = offset_ext;
                    sdata_d = store_data;
                    mis_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                lane_d = ea[1:0];
                cnt_d  = '0;
                if (mis_now) begin
                    mis_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = {ea[31:2], 2'b00};
                    we_d    = is_store;
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Ack wins over timeout when both land in the last cycle.
                if (mem_ack) begin
                    if (!is_store) ldata_d = ld_ext;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_LW;
            base_q  <= '0;
            off_q   <= '0;
            sdata_q <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            off_q   <= off_d;
            sdata_q <= sdata_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
        end
    end

    // Status outputs decode straight from the state register so that an
    // asynchronous reset drops them immediately.
    assign busy        = (state_q == S_ADDR) || (state_q == S_REQ);
    assign done        = (state_q == S_DONE);
    assign mem_req     = (state_q == S_REQ);
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_be      = be_q;
    assign load_data   = ldata_q;
    assign misaligned  = mis_q;
    assign timeout_err = tmo_q;

endmodule
